timer_controller: RTL and testbench

TIMER_CONTROLLER -- requirements
Module: timer_controller

---
 rtl/timer_controller_pkg.sv | 23 ++
 rtl/bcd_dec_mmss.sv | 35 +++
 rtl/timer_controller.sv | 133 +++++++++++++
 tb/tb_timer_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_controller_pkg.sv
// Shared definitions for the microwave cook timer: state encodings, BCD digit
// limits and the preset validity check.
package timer_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SET   = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [3:0] DIG_MAX      = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;
   localparam int         CNT_W        = 8;

   // A preset is usable only if it is a legal MM:SS BCD value.
   function automatic logic bcd_valid(input logic [15:0] p);
      return (p[15:12] <= DIG_MAX) && (p[11:8] <= DIG_MAX) &&
             (p[7:4] <= SEC_TENS_MAX) && (p[3:0] <= DIG_MAX);
   endfunction

endpackage

// File: rtl/bcd_dec_mmss.sv
// Combinational one-second decrement of a BCD MM:SS value; saturates at 0000.
// zero flags that the decremented result is 0000.
module bcd_dec_mmss
   import timer_controller_pkg::*;
(
   input  logic [15:0] t,
   output logic [15:0] q,
   output logic        zero
);

   always_comb begin
      q = t;
      if (t != 16'h0000) begin
         if (t[3:0] != 4'd0) begin
            q[3:0] = t[3:0] - 4'd1;
         end else begin
            q[3:0] = DIG_MAX;
            if (t[7:4] != 4'd0) begin
               q[7:4] = t[7:4] - 4'd1;
            end else begin
               q[7:4] = SEC_TENS_MAX;
               if (t[11:8] != 4'd0) begin
                  q[11:8] = t[11:8] - 4'd1;
               end else begin
                  q[11:8]  = DIG_MAX;
                  q[15:12] = t[15:12] - 4'd1;
               end
            end
         end
      end
   end

   assign zero = (q == 16'h0000);

endmodule

// File: rtl/timer_controller.sv
// Cook-timer control FSM: loads a BCD MM:SS preset, counts it down on prescaler
// ticks, drives the magnetron, and holds the alarm for BEEP_TICKS at the end.
module timer_controller
   import timer_controller_pkg::*;
#(
   parameter int BEEP_TICKS    = 3,
   parameter int TICKS_PER_DEC = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic [15:0] preset,
   input  logic        load,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic        door_open,
   output logic [15:0] time_bcd,
   output logic        mag_on,
   output logic        alarm,
   output logic        presc_en,
   output logic        presc_clr,
   output logic [2:0]  state_o
);

   localparam logic [CNT_W-1:0] DEC_LAST  = CNT_W'(TICKS_PER_DEC - 1);
   localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_TICKS - 1);

   state_t            state, state_n;
   logic [15:0]       time_n, dec_q;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              clr_n, dec_zero, start_ok, load_ok;

   bcd_dec_mmss u_dec (.t(time_bcd), .q(dec_q), .zero(dec_zero));

   // start loses to door_open and stop; a start that cannot act lets load through.
   assign start_ok = start & ~door_open & ~stop;
   assign load_ok  = load & bcd_valid(preset);

   always_comb begin
      state_n = state;
      time_n  = time_bcd;
      cnt_n   = cnt;
      clr_n   = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_n = '0;
            if (load_ok) begin
               state_n = ST_SET;
               time_n  = preset;
            end
         end
         ST_SET: begin
            cnt_n = '0;
            if (clear) begin
               state_n = ST_IDLE;
               time_n  = 16'h0000;
            end else if (start_ok && time_bcd != 16'h0000) begin
               state_n = ST_RUN;
               clr_n   = 1'b1;
            end else if (load_ok) begin
               time_n = preset;
            end
         end
         ST_RUN: begin
            if (clear) begin
               state_n = ST_IDLE;
               time_n  = 16'h0000;
            end else if (door_open || stop) begin
               state_n = ST_PAUSE;
            end else if (tick && !presc_clr) begin
               // presc_clr high marks the entry cycle; its tick is stale
               if (cnt == DEC_LAST) begin
                  cnt_n  = '0;
                  time_n = dec_q;
                  if (dec_zero) state_n = ST_DONE;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         ST_PAUSE: begin
            cnt_n = '0;
            if (clear) begin
               state_n = ST_IDLE;
               time_n  = 16'h0000;
            end else if (start_ok) begin
               state_n = ST_RUN;
               clr_n   = 1'b1;
            end
         end
         ST_DONE: begin
            if (clear || start || door_open) begin
               state_n = ST_IDLE;
               time_n  = 16'h0000;
            end else if (tick) begin
               if (cnt == BEEP_LAST) begin
                  state_n = ST_IDLE;
                  time_n  = 16'h0000;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            time_n  = 16'h0000;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         time_bcd  <= 16'h0000;
         cnt       <= '0;
         presc_clr <= 1'b0;
      end else begin
         state     <= state_n;
         time_bcd  <= time_n;
         cnt       <= cnt_n;
         presc_clr <= clr_n;
      end
   end

   assign mag_on   = (state == ST_RUN);
   assign alarm    = (state == ST_DONE);
   assign presc_en = (state == ST_RUN) || (state == ST_DONE);
   assign state_o  = state;

endmodule

// File: tb/tb_timer_controller.sv
// Self-checking bench for timer_controller: vector table, hand-written corner
// sequences, and randomized stimulus against a seconds-based reference model.
module tb_timer_controller;

   localparam int TPD  = 1;
   localparam int BEEP = 3;

   logic        clk = 1'b0;
   logic        reset, tick, load, start, stop, clear, door_open;
   logic [15:0] preset, time_bcd;
   logic        mag_on, alarm, presc_en, presc_clr;
   logic [2:0]  state_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   timer_controller #(.BEEP_TICKS(BEEP), .TICKS_PER_DEC(TPD)) dut (
      .clk(clk), .reset(reset), .tick(tick), .preset(preset), .load(load),
      .start(start), .stop(stop), .clear(clear), .door_open(door_open),
      .time_bcd(time_bcd), .mag_on(mag_on), .alarm(alarm), .presc_en(presc_en),
      .presc_clr(presc_clr), .state_o(state_o)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int st, input logic [15:0] t, input logic clr);
      chk({tag, " state"}, 32'(state_o), 32'(st));
      chk({tag, " time"}, 32'(time_bcd), 32'(t));
      chk({tag, " presc_clr"}, 32'(presc_clr), 32'(clr));
      chk({tag, " mag_on"}, 32'(mag_on), 32'(st == 2));
      chk({tag, " alarm"}, 32'(alarm), 32'(st == 4));
      chk({tag, " presc_en"}, 32'(presc_en), 32'(st == 2 || st == 4));
   endtask

   task automatic drive(input logic ld, input logic st, input logic sp, input logic cl,
                        input logic dr, input logic tk, input logic [15:0] pre);
      load = ld; start = st; stop = sp; clear = cl; door_open = dr; tick = tk; preset = pre;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model (time kept as plain seconds) ----------------
   int   m_st, m_sec, m_cnt;
   logic m_clr;

   function automatic int to_sec(input logic [15:0] p);
      return (int'(p[15:12]) * 10 + int'(p[11:8])) * 60 + int'(p[7:4]) * 10 + int'(p[3:0]);
   endfunction

   function automatic logic [15:0] to_bcd(input int s);
      int mm, ss;
      mm = s / 60;
      ss = s % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic logic pvalid(input logic [15:0] p);
      return p[15:12] < 10 && p[11:8] < 10 && p[7:4] < 6 && p[3:0] < 10;
   endfunction

   task automatic model_reset();
      m_st = 0; m_sec = 0; m_cnt = 0; m_clr = 1'b0;
   endtask

   task automatic model_step();
      int   ns, nsec, ncnt;
      logic nclr, sok, lok;
      ns = m_st; nsec = m_sec; ncnt = m_cnt; nclr = 1'b0;
      sok = start && !door_open && !stop;
      lok = load && pvalid(preset);
      case (m_st)
         0: if (lok) begin ns = 1; nsec = to_sec(preset); end
         1: begin
            if (clear) begin ns = 0; nsec = 0; end
            else if (sok && m_sec > 0) begin ns = 2; nclr = 1'b1; ncnt = 0; end
            else if (lok) nsec = to_sec(preset);
         end
         2: begin
            if (clear) begin ns = 0; nsec = 0; end
            else if (door_open || stop) ns = 3;
            else if (tick && !m_clr) begin
               ncnt = m_cnt + 1;
               if (ncnt == TPD) begin
                  ncnt = 0;
                  nsec = m_sec - 1;
                  if (nsec == 0) ns = 4;
               end
            end
         end
         3: begin
            if (clear) begin ns = 0; nsec = 0; end
            else if (sok) begin ns = 2; nclr = 1'b1; ncnt = 0; end
         end
         default: begin
            if (clear || start || door_open) begin ns = 0; nsec = 0; end
            else if (tick) begin
               ncnt = m_cnt + 1;
               if (ncnt == BEEP) begin ns = 0; nsec = 0; end
            end
         end
      endcase
      if (ns == 0) ncnt = 0;
      m_st = ns; m_sec = nsec; m_cnt = ncnt; m_clr = nclr;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic ld, st, sp, cl, dr, tk;
      logic [15:0] pre;
      int          es;
      logic [15:0] et;
      logic        ec;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic ld, input logic st, input logic sp, input logic cl,
                      input logic dr, input logic tk, input logic [15:0] pre,
                      input int es, input logic [15:0] et, input logic ec);
      vec_t v;
      v.ld = ld; v.st = st; v.sp = sp; v.cl = cl; v.dr = dr; v.tk = tk;
      v.pre = pre; v.es = es; v.et = et; v.ec = ec;
      tbl.push_back(v);
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 16'h0000);
      #2;
      chk_out("reset_async", 0, 16'h0000, 1'b0);
      cyc(); cyc();
      chk_out("reset", 0, 16'h0000, 1'b0);
      reset = 1'b0;

      //   ld st sp cl dr tk  preset    state time     clr
      add(1, 0, 0, 0, 0, 0, 16'h0070, 0, 16'h0000, 0);  // invalid preset
      add(1, 0, 0, 0, 0, 0, 16'h0012, 1, 16'h0012, 0);
      add(0, 1, 0, 0, 0, 0, 16'h0000, 2, 16'h0012, 1);
      add(0, 0, 0, 0, 0, 1, 16'h0000, 2, 16'h0012, 0);  // entry-cycle tick ignored
      add(0, 0, 0, 0, 0, 1, 16'h0000, 2, 16'h0011, 0);
      add(0, 0, 0, 0, 1, 1, 16'h0000, 3, 16'h0011, 0);  // door opens
      add(0, 1, 0, 0, 1, 1, 16'h0000, 3, 16'h0011, 0);  // start with door open
      add(0, 1, 0, 0, 0, 0, 16'h0000, 2, 16'h0011, 1);
      add(0, 0, 0, 0, 0, 1, 16'h0000, 2, 16'h0011, 0);
      add(0, 0, 0, 0, 0, 1, 16'h0000, 2, 16'h0010, 0);
      add(0, 1, 1, 0, 0, 0, 16'h0000, 3, 16'h0010, 0);  // stop beats start
      add(1, 0, 0, 0, 0, 0, 16'h0500, 3, 16'h0010, 0);  // load ignored in PAUSE
      add(0, 1, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0);  // clear beats start
      add(1, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 0);
      add(0, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 0);  // start at 0000 ignored
      add(1, 0, 0, 0, 0, 0, 16'h0001, 1, 16'h0001, 0);
      add(0, 1, 0, 0, 0, 0, 16'h0000, 2, 16'h0001, 1);
      add(0, 0, 0, 0, 0, 0, 16'h0000, 2, 16'h0001, 0);
      add(0, 0, 0, 0, 0, 1, 16'h0000, 4, 16'h0000, 0);
      add(0, 0, 0, 0, 0, 1, 16'h0000, 4, 16'h0000, 0);
      add(0, 0, 0, 0, 0, 1, 16'h0000, 4, 16'h0000, 0);
      add(0, 0, 0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0);  // third beep tick ends DONE
      add(1, 0, 0, 0, 0, 0, 16'h0003, 1, 16'h0003, 0);
      add(0, 1, 0, 0, 0, 0, 16'h0000, 2, 16'h0003, 1);
      add(0, 0, 0, 0, 0, 1, 16'h0000, 2, 16'h0003, 0);
      add(0, 0, 0, 0, 0, 1, 16'h0000, 2, 16'h0002, 0);
      add(0, 0, 0, 0, 0, 1, 16'h0000, 2, 16'h0001, 0);
      add(0, 0, 0, 0, 0, 1, 16'h0000, 4, 16'h0000, 0);
      add(0, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0);  // start ends DONE early
      add(1, 0, 0, 0, 0, 0, 16'h9959, 1, 16'h9959, 0);
      add(1, 0, 0, 0, 0, 0, 16'h6a00, 1, 16'h9959, 0);  // invalid reload ignored
      add(1, 0, 0, 1, 0, 0, 16'h1234, 0, 16'h0000, 0);

      foreach (tbl[i]) begin
         drive(tbl[i].ld, tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].dr, tbl[i].tk, tbl[i].pre);
         cyc();
         chk_out($sformatf("vec%0d", i), tbl[i].es, tbl[i].et, tbl[i].ec);
      end

      // BCD borrow across minutes: 10:00 -> 09:59 -> 08:59
      drive(1, 0, 0, 0, 0, 0, 16'h1000); cyc();
      drive(0, 1, 0, 0, 0, 0, 16'h0000); cyc();
      drive(0, 0, 0, 0, 0, 0, 16'h0000); cyc();
      drive(0, 0, 0, 0, 0, 1, 16'h0000); cyc();
      chk_out("borrow1", 2, 16'h0959, 1'b0);
      for (int k = 0; k < 60; k++) cyc();
      chk_out("borrow60", 2, 16'h0859, 1'b0);

      // clear + stop + tick together in RUN
      drive(0, 0, 1, 1, 0, 1, 16'h0000); cyc();
      chk_out("simul", 0, 16'h0000, 1'b0);

      // async reset mid-RUN
      drive(1, 0, 0, 0, 0, 0, 16'h0030); cyc();
      drive(0, 1, 0, 0, 0, 0, 16'h0000); cyc();
      drive(0, 0, 0, 0, 0, 1, 16'h0000); cyc();
      chk_out("prerst", 2, 16'h0030, 1'b0);
      #2 reset = 1'b1;
      #1 chk_out("rst_mid", 0, 16'h0000, 1'b0);
      #1 reset = 1'b0;
      drive(0, 1, 0, 0, 0, 1, 16'h0000); cyc();
      chk_out("rst_wait", 0, 16'h0000, 1'b0);

      // randomized run against the model
      reset = 1'b1; cyc(); reset = 1'b0;
      model_reset();
      door_open = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] mt, mo, st, so;
         mt = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         mo = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
         st = 4'($urandom_range(0, 6));
         so = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         drive($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15,
               $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2,
               ($urandom_range(0, 99) < 6) ? ~door_open : door_open,
               $urandom_range(0, 99) < 60, {mt, mo, st, so});
         model_step();
         cyc();
         chk_out($sformatf("rand%0d", n), m_st, to_bcd(m_sec), m_clr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
